// File: rtl/irq_ctrl.sv
// Interrupt controller: masked pending/overrun registers, round-robin ID offer
// over valid/ready, and an irq line with a minimum high time.
module irq_ctrl #(
  parameter int NUM_SRC       = 8,
  parameter int IRQ_HOLD_TIME = 16,
  parameter bit ERR_RESP_EN   = 1'b1,
  parameter bit IRQ_EN        = 1'b1,
  localparam int ID_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               aclk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_wdata_i,
  input  logic               clr_we_i,
  input  logic [NUM_SRC-1:0] clr_wdata_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] overrun_o,
  output logic [NUM_SRC-1:0] mask_o,
  output logic               id_valid_o,
  output logic [ID_W-1:0]    id_o,
  input  logic               id_ready_i,
  output logic               irq_o
);

  localparam int CNT_W = $clog2(IRQ_HOLD_TIME + 1);

  typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_t;
  typedef enum logic {IRQ_OFF, IRQ_ON} irq_state_t;

  generate
    if (ERR_RESP_EN && IRQ_EN) begin : g_en
      logic [NUM_SRC-1:0] r_pending;
      logic [NUM_SRC-1:0] r_overrun;
      logic [NUM_SRC-1:0] r_mask;
      logic [NUM_SRC-1:0] w_eligible;
      logic [NUM_SRC-1:0] w_clr;
      logic [NUM_SRC-1:0] w_pop;
      logic [NUM_SRC-1:0] w_cleared;
      logic               w_handshake;

      arb_state_t         r_arb_state;
      arb_state_t         w_arb_state_nxt;
      logic [ID_W-1:0]    r_id;
      logic [ID_W-1:0]    w_id_nxt;
      logic [ID_W-1:0]    r_last_grant;
      logic [ID_W-1:0]    w_last_grant_nxt;
      logic [ID_W-1:0]    w_pick;
      logic [ID_W-1:0]    w_pick_hi;
      logic [ID_W-1:0]    w_pick_lo;
      logic               w_hi_found;

      irq_state_t         r_irq_state;
      irq_state_t         w_irq_state_nxt;
      logic [CNT_W-1:0]   r_cnt;
      logic [CNT_W-1:0]   w_cnt_nxt;

      assign w_eligible  = r_pending & r_mask;
      assign w_handshake = (r_arb_state == ARB_OFFER) && id_ready_i;
      assign w_clr       = clr_we_i ? clr_wdata_i : '0;
      assign w_pop       = w_handshake ? (NUM_SRC'(1) << r_id) : '0;
      assign w_cleared   = w_clr | w_pop;

      // A new event always wins over W1C or pop in the same cycle.
      always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
          r_pending <= '0;
          r_overrun <= '0;
          r_mask    <= '0;
        end else begin
          r_pending <= src_i | (r_pending & ~w_cleared);
          r_overrun <= (src_i & r_pending & ~w_cleared) | (r_overrun & ~w_clr);
          if (mask_we_i) begin
            r_mask <= mask_wdata_i;
          end
        end
      end

      // Round-robin: lowest eligible index above last_grant, else lowest overall.
      always_comb begin
        w_pick_hi  = '0;
        w_pick_lo  = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (w_eligible[i]) begin
            w_pick_lo = ID_W'(i);
            if (i > int'(r_last_grant)) begin
              w_pick_hi  = ID_W'(i);
              w_hi_found = 1'b1;
            end
          end
        end
      end

      assign w_pick = w_hi_found ? w_pick_hi : w_pick_lo;

      always_comb begin
        w_arb_state_nxt  = r_arb_state;
        w_id_nxt         = r_id;
        w_last_grant_nxt = r_last_grant;
        case (r_arb_state)
          ARB_IDLE: begin
            if (|w_eligible) begin
              w_arb_state_nxt = ARB_OFFER;
              w_id_nxt        = w_pick;
            end
          end
          ARB_OFFER: begin
            if (id_ready_i) begin
              w_arb_state_nxt  = ARB_IDLE;
              w_last_grant_nxt = r_id;
            end
          end
        endcase
      end

      always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
          r_arb_state  <= ARB_IDLE;
          r_id         <= '0;
          r_last_grant <= ID_W'(NUM_SRC - 1);
        end else begin
          r_arb_state  <= w_arb_state_nxt;
          r_id         <= w_id_nxt;
          r_last_grant <= w_last_grant_nxt;
        end
      end

      // Hold counter is loaded only on the rising transition, never reloaded.
      always_comb begin
        w_irq_state_nxt = r_irq_state;
        w_cnt_nxt       = r_cnt;
        case (r_irq_state)
          IRQ_OFF: begin
            if (|w_eligible) begin
              w_irq_state_nxt = IRQ_ON;
              w_cnt_nxt       = CNT_W'(IRQ_HOLD_TIME - 1);
            end
          end
          IRQ_ON: begin
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end else if (!(|w_eligible)) begin
              w_irq_state_nxt = IRQ_OFF;
            end
          end
        endcase
      end

      always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
          r_irq_state <= IRQ_OFF;
          r_cnt       <= '0;
        end else begin
          r_irq_state <= w_irq_state_nxt;
          r_cnt       <= w_cnt_nxt;
        end
      end

      assign pending_o  = r_pending;
      assign overrun_o  = r_overrun;
      assign mask_o     = r_mask;
      assign id_valid_o = (r_arb_state == ARB_OFFER);
      assign id_o       = r_id;
      assign irq_o      = (r_irq_state == IRQ_ON);
    end else begin : g_off
      assign pending_o  = '0;
      assign overrun_o  = '0;
      assign mask_o     = '0;
      assign id_valid_o = 1'b0;
      assign id_o       = '0;
      assign irq_o      = 1'b0;
    end
  endgenerate

endmodule
